dense_layer_seq: RTL
====================

DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: signed data word width.
REQ-002 The block SHALL have parameter FRAC, default 24: fractional bits (Q8.24 at default).
REQ-003 The block SHALL have parameter N_IN, default 2: inputs per neuron.
REQ-004 The block SHALL have parameter N_OUT, default 9: neurons (outputs).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have port in_vec  in  N_IN*WIDTH  signed inputs; element i at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have ports in_valid  in  1 and in_ready  out  1: input handshake.
REQ-009 The block SHALL have port act_mode  in  2: 00 none, 01 ReLU, 10 hard-sigmoid, 11 hard-tanh.
REQ-010 The block SHALL have ports wr_en  in  1, wr_addr  in  16, wr_data  in  WIDTH: weight/bias write port.
REQ-011 The block SHALL have port out_vec  out  N_OUT*WIDTH  results; neuron j at bits [j*WIDTH +: WIDTH].
REQ-012 The block SHALL have ports out_valid  out  1 and out_ready  in  1: output handshake.
REQ-013 The block SHALL have ports busy  out  1 (state != IDLE) and sat_flag  out  1 (sticky per transaction).

Function
REQ-014 The FSM SHALL have states IDLE, MAC, FIN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 On in_valid&&in_ready the block SHALL latch in_vec and act_mode, clear sat_flag, set j=0, i=0 and enter MAC.
REQ-016 In MAC, each cycle SHALL add w[j][i]*x[i] (full 2*WIDTH signed product) to acc; at i=0, acc = (bias[j]<<<FRAC) + product; after i=N_IN-1 the FSM SHALL enter FIN.
REQ-017 acc SHALL be at least 2*WIDTH+4 bits and SHALL NOT overflow for any N_IN<=16.
REQ-018 In FIN, y = acc>>>FRAC (arithmetic, floor) saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; a clamp SHALL set sat_flag.
REQ-019 The activation of the saturated y SHALL be: none = y; ReLU = max(y,0); hard-sigmoid = clamp((y>>>2) + 2^(FRAC-1), 0, 2^FRAC); hard-tanh = clamp(y, -2^FRAC, 2^FRAC).
REQ-020 FIN SHALL write the activation result to out_vec element j; if j<N_OUT-1, then j++, i=0, back to MAC; else DONE.
REQ-021 out_valid SHALL rise exactly L = N_OUT*(N_IN+1) rising edges after the accepting edge (27 at defaults).
REQ-022 In DONE, out_valid=1 and out_vec and sat_flag SHALL hold stable until out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-023 out_vec elements SHALL retain their last values in IDLE and SHALL be overwritten only in FIN.
REQ-024 Writes SHALL take effect only in IDLE: addresses 0..N_OUT*N_IN-1 are w[j][i] at j*N_IN+i; N_OUT*N_IN+j is bias[j], in integer Q format.
REQ-025 Writes outside IDLE and out-of-range addresses SHALL be ignored without error.
REQ-026 When wr_en and the input handshake occur on the same IDLE edge, the write SHALL commit and the transaction SHALL use the new value.
REQ-027 in_valid outside IDLE SHALL be ignored; input data SHALL NOT be queued.

Reset
REQ-028 On rst=1 at a rising edge, state SHALL become IDLE and in_ready=1; out_valid, busy and sat_flag SHALL be 0.
REQ-029 On reset, out_vec, all weights, all biases, acc, j and i SHALL be 0.
REQ-030 Reset SHALL take priority over every other input, including mid-MAC and DONE; no partial result SHALL survive it.

Verification
REQ-031 Defaults, w[j][0]=0x01000000, w[j][1]=0, biases 0, mode 00, in=(0, 0x01000000) -> all 9 outputs 0x00000000; then in=(0x01000000, 0) -> all 0x01000000; out_valid exactly 27 edges after accept.
REQ-032 Mode 01, w[j][0]=0xFF000000 (-1.0), in=(0x01000000, 0) -> all outputs 0; mode 00 -> all 0xFF000000.
REQ-033 w[j][0]=0x64000000 (100.0), in=(0x02000000, 0), mode 00 -> all 0x7FFFFFFF and sat_flag=1; mode 11 -> all 0x01000000.
REQ-034 Mode 10, all weights and biases 0 -> all outputs 0x00800000; bias 0x08000000 -> 0x01000000.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid, pulse in_valid and wr_en meanwhile -> out_vec unchanged, weights unchanged, in_ready=0; one cycle after out_ready=1, in_ready=1.
REQ-036 Assert rst at cycle 10 of a MAC run -> next cycle state IDLE, out_valid=0, out_vec=0, readback computation with in=(1.0, 1.0) gives all 0.

Source files
------------

// File: rtl/dense_layer_seq_if.sv
// Handshake, configuration and result bundle for dense_layer_seq.
// The master side drives inputs and weight writes; the slave side is the layer itself.
interface dense_layer_seq_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 9
);
  logic [N_IN*WIDTH-1:0]  in_vec;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             act_mode;
  logic                   wr_en;
  logic [15:0]            wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [N_OUT*WIDTH-1:0] out_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   sat_flag;

  modport master (
    output in_vec, in_valid, act_mode, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_vec, out_valid, busy, sat_flag
  );

  modport slave (
    input  in_vec, in_valid, act_mode, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_vec, out_valid, busy, sat_flag
  );
endinterface

// File: rtl/dense_layer_seq.sv
// Sequential fixed-point dense layer: one multiply-accumulate per cycle, then one
// saturate/activate cycle per neuron, with a hold-until-ready result stage.
module dense_layer_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int N_IN  = 2,
  parameter int N_OUT = 9
) (
  input logic               clk,
  input logic               rst,
  dense_layer_seq_if.slave  bus
);
  localparam int ACC_W = 2*WIDTH + 4;
  localparam int AW    = WIDTH + 2;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW    = N_OUT * N_IN;

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    ONE   = AW'(1) << FRAC;
  localparam logic signed [AW-1:0]    NONE  = -ONE;
  localparam logic signed [AW-1:0]    HALF  = AW'(1) << (FRAC-1);

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] weight_q [N_OUT][N_IN];
  logic signed [WIDTH-1:0] bias_q   [N_OUT];
  logic signed [WIDTH-1:0] xVec_q   [N_IN];
  logic signed [WIDTH-1:0] result_q [N_OUT];
  logic signed [ACC_W-1:0] accum_q;
  logic [1:0]              mode_q;
  logic [JW-1:0]           j_q;
  logic [IW-1:0]           i_q;
  logic                    sat_q;
  logic                    inReady_q;
  logic                    outValid_q;
  logic                    busy_q;

  logic signed [2*WIDTH-1:0] prod_d;
  logic signed [ACC_W-1:0]   prodExt_d;
  logic signed [ACC_W-1:0]   biasExt_d;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   yWide_d;
  logic signed [WIDTH-1:0]   ySat_d;
  logic signed [AW-1:0]      yExt_d;
  logic signed [AW-1:0]      hsig_d;
  logic signed [WIDTH-1:0]   act_d;
  logic                      satHit_d;
  logic [N_OUT*WIDTH-1:0]    outPack_d;

  // Datapath: the accumulator restarts from the shifted bias on the first input of each neuron.
  always_comb begin
    prod_d    = (2*WIDTH)'(weight_q[j_q][i_q]) * (2*WIDTH)'(xVec_q[i_q]);
    prodExt_d = ACC_W'(prod_d);
    biasExt_d = ACC_W'(bias_q[j_q]) <<< FRAC;
    acc_d     = (i_q == '0) ? (biasExt_d + prodExt_d) : (accum_q + prodExt_d);

    yWide_d  = accum_q >>> FRAC;
    satHit_d = 1'b0;
    ySat_d   = yWide_d[WIDTH-1:0];
    if (yWide_d > ACC_W'(S_MAX)) begin
      ySat_d   = S_MAX;
      satHit_d = 1'b1;
    end else if (yWide_d < ACC_W'(S_MIN)) begin
      ySat_d   = S_MIN;
      satHit_d = 1'b1;
    end

    yExt_d = AW'(ySat_d);
    hsig_d = (yExt_d >>> 2) + HALF;
    act_d  = ySat_d;
    unique case (mode_q)
      2'b00: act_d = ySat_d;
      2'b01: act_d = ySat_d[WIDTH-1] ? '0 : ySat_d;
      2'b10: begin
        if (hsig_d < 0)        act_d = '0;
        else if (hsig_d > ONE) act_d = ONE[WIDTH-1:0];
        else                   act_d = hsig_d[WIDTH-1:0];
      end
      2'b11: begin
        if (yExt_d > ONE)       act_d = ONE[WIDTH-1:0];
        else if (yExt_d < NONE) act_d = NONE[WIDTH-1:0];
        else                    act_d = ySat_d;
      end
    endcase

    outPack_d = '0;
    for (int k = 0; k < N_OUT; k++) outPack_d[k*WIDTH +: WIDTH] = result_q[k];
  end

  // Control FSM; parameter writes are only honoured while idle so a running job sees stable weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      accum_q    <= '0;
      mode_q     <= '0;
      j_q        <= '0;
      i_q        <= '0;
      sat_q      <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int jj = 0; jj < N_OUT; jj++) begin
        bias_q[jj]   <= '0;
        result_q[jj] <= '0;
        for (int ii = 0; ii < N_IN; ii++) weight_q[jj][ii] <= '0;
      end
      for (int ii = 0; ii < N_IN; ii++) xVec_q[ii] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.wr_en) begin
            for (int jj = 0; jj < N_OUT; jj++) begin
              if (bus.wr_addr == 16'(NW + jj)) bias_q[jj] <= bus.wr_data;
              for (int ii = 0; ii < N_IN; ii++)
                if (bus.wr_addr == 16'(jj*N_IN + ii)) weight_q[jj][ii] <= bus.wr_data;
            end
          end
          if (bus.in_valid) begin
            for (int ii = 0; ii < N_IN; ii++) xVec_q[ii] <= bus.in_vec[ii*WIDTH +: WIDTH];
            mode_q    <= bus.act_mode;
            sat_q     <= 1'b0;
            j_q       <= '0;
            i_q       <= '0;
            state_q   <= MAC;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        MAC: begin
          accum_q <= acc_d;
          if (i_q == IW'(N_IN-1)) state_q <= FIN;
          else                    i_q     <= i_q + IW'(1);
        end
        FIN: begin
          result_q[j_q] <= act_d;
          if (satHit_d) sat_q <= 1'b1;
          if (j_q == JW'(N_OUT-1)) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end else begin
            j_q     <= j_q + JW'(1);
            i_q     <= '0;
            state_q <= MAC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy_q;
  assign bus.sat_flag  = sat_q;
  assign bus.out_vec   = outPack_d;
endmodule
